collision_event_tracker: RTL and testbench
==========================================

Name: collision_event_tracker

Overview:
Parametrised per-frame collision detector between one primary sprite (player) and NUM_OBJ object layers (floors, ropes, fruits, goal, ...). Per channel it produces:
- a live collision level;
- a single registered hit pulse per frame;
- a saturating hit counter.

At every frame boundary it also publishes a snapshot of which channels were hit during the previous frame, plus the lowest-index hit channel. It sits between the VGA draw-request mux and the game-logic FSMs (score, lives, climbing).

Parameters:
NUM_OBJ, 4, number of object channels (1..16)
CNT_W, 4, width of each per-channel hit counter
IDX_W, 2, width of the channel index; must equal max(1, $clog2(NUM_OBJ))

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse at start of each frame
playerDR  in  1  player sprite draw request for the current pixel
objDR  in  NUM_OBJ  object draw requests; bit i = channel i
chanEn  in  NUM_OBJ  per-channel enable mask; 0 = channel ignored
clrCount  in  1  synchronous clear of all hit counters
collision  out  NUM_OBJ  combinational: playerDR & objDR[i] & chanEn[i]
hitPulse  out  NUM_OBJ  registered one-cycle pulse; first collision of channel i in a frame
frameHit  out  NUM_OBJ  registered snapshot: channels that collided during the previous frame
firstHitIdx  out  IDX_W  lowest set index of frameHit; 0 when none
firstHitValid  out  1  frameHit != 0
hitCount  out  NUM_OBJ*CNT_W  packed counters; channel i in bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (async, resetN=0): hitPulse, frameHit, firstHitIdx, firstHitValid, all hitCount = 0. Internal armed flags = 0 (armed). Internal accumulators = 0.
- collision is purely combinational, with no latency. Disabled channels never collide.
- Per channel i, per cycle:
  - If startOfFrame: flag_i is treated as cleared for this cycle. The collision in this same cycle belongs to the NEW frame.
  - hitPulse[i] <= collision[i] & ~flag_eff_i, where flag_eff_i = flag_i & ~startOfFrame.
  - flag_i <= (flag_eff_i | collision[i]).
  - Latency: collision at cycle t gives hitPulse at t+1. At most one hitPulse per channel per frame, independent of other channels.
- Accumulator acc_i:
  - On startOfFrame: acc_i <= collision[i]. Else: acc_i <= acc_i | collision[i].
- Snapshot on startOfFrame:
  - frameHit <= acc (value before update, i.e. excluding the current cycle).
  - firstHitIdx <= lowest set index of that acc; firstHitValid <= |acc.
  - Outputs hold for the whole frame.
  - The first startOfFrame after reset publishes all zeros.
- Counters:
  - On the cycle hitPulse[i] is asserted, hitCount_i increments, saturating at 2^CNT_W-1 (no wrap).
  - clrCount has priority: if clrCount and an increment coincide, the result is 0.
- chanEn falling mid-frame: the channel stops colliding immediately. Its flag and acc keep their values until the next startOfFrame.
- startOfFrame while the frame is already idle (no collisions) is legal; it publishes zero.
- Mid-operation reset: every state register returns to its reset value asynchronously. No pulse is emitted on release.

Decomposition:
- Package collision_pkg:
  - channel index constants (CH_FLOOR=0, CH_ROPE=1, CH_FRUIT=2, CH_GOAL=3);
  - default NUM_OBJ/CNT_W;
  - function to compute the lowest-set-bit index.
- Sub-module collision_channel: holds flag, acc, hitPulse bit and saturating counter for one channel. It is instantiated NUM_OBJ times in a generate loop.
- Top level: combinational collision vector, snapshot registers and priority encoder.

Test Plan:
- Reset, then playerDR=1, objDR=4'b0010, chanEn=4'hF for 10 cycles in one frame -> collision=0010 every cycle; hitPulse[1] high exactly once, one cycle after the first overlap; hitCount[1]=1.
- Next startOfFrame after that frame -> frameHit=0010, firstHitIdx=1, firstHitValid=1. A following frame with no collisions -> next snapshot frameHit=0, firstHitValid=0.
- Collision on ch0 and ch3 during frame N -> snapshot frameHit=1001, firstHitIdx=0. Collision on ch0 asserted exactly in the startOfFrame cycle -> hitPulse[0] fires on the next cycle and counts toward frame N+1, not N.
- chanEn=4'b1110 with objDR=4'b0001 and playerDR=1 -> collision=0, no hitPulse, hitCount[0] stays 0.
- CNT_W=4, ch2 hit in 20 consecutive frames -> hitCount[2] saturates at 15. Then clrCount asserted in the same cycle as a hitPulse[2] -> hitCount[2]=0.
- Assert resetN=0 mid-frame with flags set, release, collide again in the same frame -> a fresh hitPulse is issued; frameHit=0 until the next snapshot.

Source files
------------

// File: rtl/collision_pkg.sv
// ---------------------------------------------------------------------------
// collision_pkg
// Shared definitions for the collision event tracker:
//   - channel index constants for the standard object layers
//   - default channel count and counter width
//   - lowest_set_idx(): priority encoder (lowest set bit wins)
// ---------------------------------------------------------------------------
package collision_pkg;

    // Standard object layer assignment
    localparam int CH_FLOOR = 0;
    localparam int CH_ROPE  = 1;
    localparam int CH_FRUIT = 2;
    localparam int CH_GOAL  = 3;

    localparam int DEF_NUM_OBJ = 4;
    localparam int DEF_CNT_W   = 4;

    // Maximum supported channel count; the encoder works on a vector of this width.
    localparam int MAX_OBJ = 16;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_set_idx(input logic [MAX_OBJ-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        // Scanning downwards lets the lowest set bit overwrite any higher one.
        for (int i = MAX_OBJ - 1; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/collision_channel.sv
// ---------------------------------------------------------------------------
// collision_channel
// Per-channel state for the collision event tracker.
// Ports:
//   clk, resetN    clock, asynchronous active-low reset
//   startOfFrame   frame boundary pulse
//   collision      live collision level for this channel
//   clrCount       synchronous clear of the hit counter
//   hitPulse       one-cycle pulse on the first collision of a frame
//   acc            "collided at least once this frame" accumulator
//   hitCount       saturating count of hit pulses
// ---------------------------------------------------------------------------
module collision_channel
    import collision_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             collision,
    input  logic             clrCount,
    output logic             hitPulse,
    output logic             acc,
    output logic [CNT_W-1:0] hitCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic flag;      // set once this channel has pulsed in the current frame
    logic flag_eff;  // flag as seen this cycle; a frame boundary re-arms it

    // A collision in the startOfFrame cycle belongs to the new frame,
    // so the old flag must not suppress its pulse.
    assign flag_eff = flag & ~startOfFrame;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flag     <= 1'b0;
            acc      <= 1'b0;
            hitPulse <= 1'b0;
            hitCount <= '0;
        end else begin
            hitPulse <= collision & ~flag_eff;
            flag     <= flag_eff | collision;
            acc      <= startOfFrame ? collision : (acc | collision);

            // Clear wins over a coincident increment.
            if (clrCount) begin
                hitCount <= '0;
            end else if (hitPulse && (hitCount != CNT_MAX)) begin
                hitCount <= hitCount + 1'b1;
            end
        end
    end

endmodule

// File: rtl/collision_event_tracker.sv
// ---------------------------------------------------------------------------
// collision_event_tracker
// Per-frame collision detector between the player sprite and NUM_OBJ object
// layers.
// Ports:
//   clk, resetN    clock, asynchronous active-low reset
//   startOfFrame   one-cycle pulse at the start of each frame
//   playerDR       player draw request for the current pixel
//   objDR          object draw requests, bit i = channel i
//   chanEn         per-channel enable mask
//   clrCount       synchronous clear of all hit counters
//   collision      combinational playerDR & objDR & chanEn
//   hitPulse       registered first-collision-of-frame pulse per channel
//   frameHit       channels hit during the previous frame
//   firstHitIdx    lowest index set in frameHit (0 when none)
//   firstHitValid  frameHit is non-zero
//   hitCount       packed saturating counters, channel i at [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module collision_event_tracker
    import collision_pkg::*;
#(
    parameter int NUM_OBJ = DEF_NUM_OBJ,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int IDX_W   = 2
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic                     playerDR,
    input  logic [NUM_OBJ-1:0]       objDR,
    input  logic [NUM_OBJ-1:0]       chanEn,
    input  logic                     clrCount,
    output logic [NUM_OBJ-1:0]       collision,
    output logic [NUM_OBJ-1:0]       hitPulse,
    output logic [NUM_OBJ-1:0]       frameHit,
    output logic [IDX_W-1:0]         firstHitIdx,
    output logic                     firstHitValid,
    output logic [NUM_OBJ*CNT_W-1:0] hitCount
);

    logic [NUM_OBJ-1:0] acc;        // per-channel "hit during this frame"
    logic [MAX_OBJ-1:0] acc_ext;    // acc zero-extended for the encoder
    logic [3:0]         first_idx;

    // Disabled channels never collide; no pipeline delay on this path.
    assign collision = {NUM_OBJ{playerDR}} & objDR & chanEn;

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_chan
        collision_channel #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .collision    (collision[g]),
            .clrCount     (clrCount),
            .hitPulse     (hitPulse[g]),
            .acc          (acc[g]),
            .hitCount     (hitCount[g*CNT_W +: CNT_W])
        );
    end

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_ext              = '0;
        acc_ext[NUM_OBJ-1:0] = acc;
        first_idx            = lowest_set_idx(acc_ext);
    end

    // The snapshot takes acc before this cycle's update, so it covers exactly
    // the frame that is ending; collisions in the boundary cycle go to the
    // next frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frameHit      <= '0;
            firstHitIdx   <= '0;
            firstHitValid <= 1'b0;
        end else if (startOfFrame) begin
            frameHit      <= acc;
            firstHitIdx   <= first_idx[IDX_W-1:0];
            firstHitValid <= |acc;
        end
    end

endmodule

// File: tb/tb_collision_event_tracker.sv
// ---------------------------------------------------------------------------
// tb_collision_event_tracker
// Scoreboard bench: the driver applies one stimulus vector per cycle, asks a
// frame-level reference model what the DUT must show during that cycle, and
// queues it; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_collision_event_tracker;

    localparam int NUM_OBJ = 4;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_CAP = (1 << CNT_W) - 1;

    logic                     clk;
    logic                     resetN;
    logic                     startOfFrame;
    logic                     playerDR;
    logic [NUM_OBJ-1:0]       objDR;
    logic [NUM_OBJ-1:0]       chanEn;
    logic                     clrCount;
    logic [NUM_OBJ-1:0]       collision;
    logic [NUM_OBJ-1:0]       hitPulse;
    logic [NUM_OBJ-1:0]       frameHit;
    logic [IDX_W-1:0]         firstHitIdx;
    logic                     firstHitValid;
    logic [NUM_OBJ*CNT_W-1:0] hitCount;

    collision_event_tracker #(
        .NUM_OBJ(NUM_OBJ),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .playerDR     (playerDR),
        .objDR        (objDR),
        .chanEn       (chanEn),
        .clrCount     (clrCount),
        .collision    (collision),
        .hitPulse     (hitPulse),
        .frameHit     (frameHit),
        .firstHitIdx  (firstHitIdx),
        .firstHitValid(firstHitValid),
        .hitCount     (hitCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_OBJ-1:0]       coll;
        logic [NUM_OBJ-1:0]       hp;
        logic [NUM_OBJ-1:0]       fh;
        logic [IDX_W-1:0]         idx;
        logic                     valid;
        logic [NUM_OBJ*CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, kept in frame-level terms.
    logic [NUM_OBJ-1:0] seen_this_frame;  // channels that already pulsed this frame
    logic [NUM_OBJ-1:0] hit_this_frame;   // channels touched this frame
    logic [NUM_OBJ-1:0] m_hp;             // pulses the DUT shows this cycle
    logic [NUM_OBJ-1:0] m_fh;
    logic [IDX_W-1:0]   m_idx;
    logic               m_valid;
    int                 m_cnt[NUM_OBJ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        seen_this_frame = '0;
        hit_this_frame  = '0;
        m_hp            = '0;
        m_fh            = '0;
        m_idx           = '0;
        m_valid         = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) m_cnt[i] = 0;
    endtask

    // One clock cycle of stimulus. Inputs change just after the rising edge.
    task automatic step(input logic rst_n, input logic sof, input logic pdr,
                        input logic [NUM_OBJ-1:0] obj, input logic [NUM_OBJ-1:0] en,
                        input logic clr);
        exp_t               e;
        logic [NUM_OBJ-1:0] coll;
        logic [NUM_OBJ-1:0] published;
        @(posedge clk);
        #1;
        resetN       = rst_n;
        startOfFrame = sof;
        playerDR     = pdr;
        objDR        = obj;
        chanEn       = en;
        clrCount     = clr;

        coll = pdr ? (obj & en) : '0;
        if (!rst_n) model_reset();

        e.coll  = coll;
        e.hp    = m_hp;
        e.fh    = m_fh;
        e.idx   = m_idx;
        e.valid = m_valid;
        for (int i = 0; i < NUM_OBJ; i++) e.cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        exp_q.push_back(e);

        // Advance the model to what the next rising edge must produce.
        if (rst_n) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (clr)          m_cnt[i] = 0;
                else if (m_hp[i]) m_cnt[i] = (m_cnt[i] + 1 > CNT_CAP) ? CNT_CAP : m_cnt[i] + 1;
            end
            if (sof) begin
                published       = hit_this_frame;
                seen_this_frame = '0;
                hit_this_frame  = '0;
                m_fh            = published;
                m_valid         = (published != 0);
                m_idx           = '0;
                for (int i = NUM_OBJ - 1; i >= 0; i--) if (published[i]) m_idx = IDX_W'(i);
            end
            m_hp            = coll & ~seen_this_frame;
            seen_this_frame = seen_this_frame | coll;
            hit_this_frame  = hit_this_frame | coll;
        end
    endtask

    // Monitor: compares every queued expectation in the middle of its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("collision",     32'(collision),     32'(e.coll));
                check("hitPulse",      32'(hitPulse),      32'(e.hp));
                check("frameHit",      32'(frameHit),      32'(e.fh));
                check("firstHitIdx",   32'(firstHitIdx),   32'(e.idx));
                check("firstHitValid", 32'(firstHitValid), 32'(e.valid));
                check("hitCount",      32'(hitCount),      32'(e.cnt));
            end
        end
    end

    initial begin
        logic [NUM_OBJ-1:0] r_obj;
        logic [NUM_OBJ-1:0] r_en;
        model_reset();
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        playerDR     = 1'b0;
        objDR        = '0;
        chanEn       = '0;
        clrCount     = 1'b0;

        // Reset
        repeat (2) step(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);

        // Ten-cycle overlap on the rope channel: one pulse, count 1
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b1, 4'b0010, 4'hF, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("rope_count_after_frame", 32'(hitCount[1*CNT_W +: CNT_W]), 32'd1);

        // Snapshot of the rope frame, then an empty frame
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("rope_snapshot", 32'(frameHit), 32'b0010);
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("empty_snapshot_valid", 32'(firstHitValid), 32'd0);

        // Frame N: floor + goal; floor collides again in the boundary cycle
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b1, 4'b1001, 4'hF, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'b0001, 4'hF, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("boundary_pulse_ch0", 32'(hitPulse[0]), 32'd1);
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);

        // Disabled channel never collides
        repeat (4) step(1'b1, 1'b0, 1'b1, 4'b0001, 4'b1110, 1'b0);

        // Fruit hit in 20 consecutive frames saturates its counter
        for (int f = 0; f < 20; f++) begin
            step(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
            step(1'b1, 1'b0, 1'b1, 4'b0100, 4'hF, 1'b0);
            step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("fruit_saturated", 32'(hitCount[2*CNT_W +: CNT_W]), 32'd15);

        // Clear coinciding with a fruit pulse wins
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'b0100, 4'hF, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b1);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("fruit_cleared", 32'(hitCount[2*CNT_W +: CNT_W]), 32'd0);

        // Mid-frame reset with flags set, then a fresh pulse in the same frame
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b1, 4'b0010, 4'hF, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'b0010, 4'hF, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("pulse_after_reset", 32'(hitPulse[1]), 32'd1);
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            r_obj = NUM_OBJ'($urandom);
            r_en  = ($urandom_range(3) == 0) ? NUM_OBJ'($urandom) : 4'hF;
            step(($urandom_range(299) != 0),
                 ($urandom_range(11) == 0),
                 ($urandom_range(1) == 1),
                 r_obj, r_en,
                 ($urandom_range(49) == 0));
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
